input_window_buffer: RTL and testbench
======================================

# input_window_buffer

Frame buffer and 3x3 window generator sitting directly downstream of the input write controller in the 9-multiplier convolution datapath. It accepts raster-order pixels while `wr` is high and asserts `full` once a complete frame is stored, which tells the write controller to stop. It then presents every valid 3x3 window, with all nine pixels in parallel, to the multiplier array over a valid/ready handshake. It signals `done` after the last window and rearms on `clear`.

## Interface
- `DATA_W`, 8, pixel width in bits.
- `IMG_W`, 8, image width in pixels; must be >= 3.
- `IMG_H`, 8, image height in pixels; must be >= 3.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous active-low reset; the block is held in reset while `rst` is 0.
- `wr`  input  1  pixel write strobe from the write controller.
- `din`  input  DATA_W  pixel data, sampled when `wr` is high.
- `clear`  input  1  synchronous one-cycle command that discards the frame and returns the block to FILL.
- `full`  output  1  frame completely stored; registered.
- `win_valid`  output  1  the current window is presented.
- `win_ready`  input  1  the consumer accepts the window.
- `win_data`  output  9*DATA_W  window pixels; element k=3*r+c (r = window row 0..2, c = window column 0..2) is at bits [k*DATA_W +: DATA_W].
- `win_row`  output  clog2(IMG_H)  top-left row of the current window.
- `win_col`  output  clog2(IMG_W)  top-left column of the current window.
- `done`  output  1  all windows of the frame have been accepted; registered.

## Operation
- Storage: IMG_W*IMG_H register array, not reset, written at address `wptr`.
- FSM states: FILL, SEND, DONE. Reset state is FILL.
- FILL:
  - When `wr`=1, store `din` at `wptr`, then increment `wptr`.
  - The write to address IMG_W*IMG_H-1 moves the FSM to SEND and sets `full`=1 on the same edge.
- SEND:
  - `win_valid`=1.
  - `win_data` element (r,c) = mem[(win_row+r)*IMG_W + win_col + c]; this read is combinational.
  - A window is accepted on any cycle with `win_valid` and `win_ready` both high.
  - On acceptance: if `win_col`=IMG_W-3, `win_col` wraps to 0 and `win_row` increments; otherwise `win_col` increments.
  - Acceptance of the window at (IMG_H-3, IMG_W-3) moves the FSM to DONE.
  - Window count per frame = (IMG_H-2)*(IMG_W-2), in raster order.
- DONE: `done`=1, `full` stays 1, `win_valid`=0.
- `clear` (any state): on the next edge, state becomes FILL and `wptr`, `win_row`, `win_col`, `full`, `done` all become 0. Memory contents are left unchanged.
- Boundary conditions:
  - `wr` is ignored in SEND and DONE. The write controller still holds `wr`=1 for the cycle in which it first sees `full`; that write must not corrupt the stored frame.
  - `clear` and `wr` in the same cycle: `clear` wins and the write is dropped.
  - `clear` and window acceptance in the same cycle: `clear` wins and the counters go to 0.
  - `win_ready` held low in SEND: the window, `win_row` and `win_col` stay stable indefinitely.
  - `win_data` is forced to 0 whenever `win_valid`=0.
  - Reset asserted mid-frame or mid-SEND: all state is cleared immediately, with no dependence on the clock.

## Timing
- Reset values: `full`=0, `done`=0, `win_valid`=0, `win_data`=0, `win_row`=0, `win_col`=0.
- A write becomes visible in memory on the edge after `wr` is sampled.
- `full` rises on the edge that stores the last pixel.
- `win_valid` rises on that same edge, so the first window is available 0 cycles after `full`.
- With `win_ready` tied to 1, one window is accepted per cycle.
- `done` rises on the edge that accepts the last window; `win_valid` falls on the same edge.
- `clear` takes effect on the next edge, so `full`, `done` and `win_valid` read 0 in the following cycle.
- Throughput, back-to-back frames: IMG_W*IMG_H fill cycles, plus (IMG_H-2)*(IMG_W-2) send cycles, plus 1 `clear` cycle.

## Test plan
- Reset and fill, with IMG_W=4, IMG_H=4:
  - Release `rst`, drive `wr`=1 with `din`=0..15 on 16 consecutive cycles.
  - Required: `full`=1 after the 16th edge, and the first window `win_data` = {0,1,2,4,5,6,8,9,10} with `win_row`=0, `win_col`=0.
- Window sweep with `win_ready`=1:
  - Required: 4 windows at (0,0), (0,1), (1,0), (1,1).
  - Window (1,1) = {5,6,7,9,10,11,13,14,15}.
  - `done`=1 on the 4th acceptance edge; `win_valid`=0 afterwards.
- Backpressure: `win_ready`=0 for 5 cycles at window (0,1).
  - Required: `win_data` = {1,2,3,5,6,7,9,10,11} held stable and `win_col`=1 throughout.
- Extra write after full: hold `wr`=1 with `din`=8'hFF for 2 cycles after `full` rises.
  - Required: all windows are unchanged and no 8'hFF appears in them.
- `clear` in mid-SEND, then a refill with `din`=100..115.
  - Required: `full`, `done` and the counters are 0 one cycle later.
  - The new first window = {100,101,102,104,105,106,108,109,110}.
- Async reset mid-fill: pull `rst` low between edges after 7 writes.
  - Required: all outputs reach their reset values immediately.
  - A subsequent full 16-pixel fill completes normally.

Source files
------------

// File: rtl/input_window_buffer_if.sv
// ----------------------------------------------------------------------------
// input_window_buffer_if
//   Bundles the pixel-write side and the window-output side of the
//   input_window_buffer into one interface.
//
//   Signals:
//     wr, din      pixel write strobe and pixel data from the write controller
//     clear        one-cycle command that discards the frame and rearms
//     full         a complete frame is stored (write controller must stop)
//     win_valid    a 3x3 window is being presented
//     win_ready    consumer accepts the current window
//     win_data     nine window pixels, element 3*r+c at [k*DATA_W +: DATA_W]
//     win_row      top-left row of the current window
//     win_col      top-left column of the current window
//     done         all windows of the frame have been accepted
//
//   Modports:
//     master  the surrounding datapath (write controller + multiplier array)
//     slave   the buffer itself
// ----------------------------------------------------------------------------
interface input_window_buffer_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  logic                wr;
  logic [DATA_W-1:0]   din;
  logic                clear;
  logic                full;
  logic                win_valid;
  logic                win_ready;
  logic [9*DATA_W-1:0] win_data;
  logic [ROW_W-1:0]    win_row;
  logic [COL_W-1:0]    win_col;
  logic                done;

  // The datapath side drives commands and the consumer's ready.
  modport master (
    output wr, din, clear, win_ready,
    input  full, win_valid, win_data, win_row, win_col, done
  );

  // The buffer receives commands and presents the window.
  modport slave (
    input  wr, din, clear, win_ready,
    output full, win_valid, win_data, win_row, win_col, done
  );
endinterface

// File: rtl/input_window_buffer.sv
// ----------------------------------------------------------------------------
// input_window_buffer
//   Frame buffer and 3x3 window generator for the 9-multiplier convolution
//   datapath. Pixels arrive in raster order while wr is high; once the last
//   pixel of the frame is stored, full is raised and every valid 3x3 window
//   is presented in raster order over a valid/ready handshake. done is
//   raised when the last window has been accepted; clear rearms the block.
//
//   Ports:
//     clk   single rising-edge clock
//     rst   asynchronous active-low reset
//     bus   input_window_buffer_if.slave (write side + window side)
//
//   Parameters:
//     DATA_W  pixel width in bits
//     IMG_W   image width in pixels (>= 3)
//     IMG_H   image height in pixels (>= 3)
// ----------------------------------------------------------------------------
module input_window_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input logic                  clk,
  input logic                  rst,
  input_window_buffer_if.slave bus
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int AW    = $clog2(NPIX);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  localparam logic [AW-1:0]    LAST_ADDR = AW'(NPIX - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 3);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 3);

  typedef enum logic [1:0] {
    FILL,
    SEND,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              full_q, full_d;
  logic              done_q, done_d;
  logic              mem_we;
  logic              accept;

  logic [DATA_W-1:0] mem [NPIX];

  assign accept = (state_q == SEND) && bus.win_ready;

  // Next-state and counter logic. clear overrides everything, including a
  // write or a window acceptance in the same cycle. In FILL, the write to
  // the last address hands over to SEND and raises full on the same edge;
  // wptr is left parked there since clear or reset reloads it before the
  // next frame. Writes arriving in SEND or DONE are dropped, which protects
  // the stored frame from the write controller's one-cycle reaction lag.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    row_d   = row_q;
    col_d   = col_q;
    full_d  = full_q;
    done_d  = done_q;
    mem_we  = 1'b0;

    if (bus.clear) begin
      state_d = FILL;
      wptr_d  = '0;
      row_d   = '0;
      col_d   = '0;
      full_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (bus.wr) begin
            mem_we = 1'b1;
            if (wptr_q == LAST_ADDR) begin
              state_d = SEND;
              full_d  = 1'b1;
            end else begin
              wptr_d = wptr_q + 1'b1;
            end
          end
        end
        SEND: begin
          if (accept) begin
            if (row_q == LAST_ROW && col_q == LAST_COL) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  // State, pointer and flag registers. Reset is asynchronous so that
  // pulling rst low clears full/done/win_valid and the counters at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      wptr_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      full_q  <= full_d;
      done_q  <= done_d;
    end
  end

  // Pixel storage. Deliberately not reset: contents are only meaningful
  // once a full frame has been written, and clear leaves them untouched.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr_q] <= bus.din;
    end
  end

  // Window read-out. All nine taps are read combinationally from the frame
  // so the multiplier array sees the whole window in the same cycle. The
  // bus is held at zero whenever no window is being offered.
  always_comb begin
    bus.win_data = '0;
    if (state_q == SEND) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          bus.win_data[(3*r + c)*DATA_W +: DATA_W] =
            mem[AW'((int'(row_q) + r) * IMG_W + int'(col_q) + c)];
        end
      end
    end
  end

  assign bus.win_valid = (state_q == SEND);
  assign bus.full      = full_q;
  assign bus.done      = done_q;
  assign bus.win_row   = row_q;
  assign bus.win_col   = col_q;

endmodule

// File: tb/tb_input_window_buffer.sv
// ----------------------------------------------------------------------------
// tb_input_window_buffer
//   Self-checking bench for input_window_buffer on a 4x4 image with 8-bit
//   pixels. The reference model tracks only how many pixels have been stored
//   and how many windows have been accepted; every expected output (full,
//   done, win_valid, window position and contents) is derived from those two
//   counts and a copy of the stored frame.
// ----------------------------------------------------------------------------
module tb_input_window_buffer;

  localparam int DW   = 8;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  input_window_buffer_if #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) bus ();

  input_window_buffer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic [DW-1:0] m_pix [NPIX];
  int            m_stored   = 0;
  int            m_accepted = 0;

  function automatic bit model_full();
    return m_stored == NPIX;
  endfunction

  function automatic bit model_done();
    return m_accepted == NWIN;
  endfunction

  function automatic bit model_valid();
    return (m_stored == NPIX) && (m_accepted < NWIN);
  endfunction

  function automatic int model_row();
    return m_accepted / (W - 2);
  endfunction

  function automatic int model_col();
    return m_accepted % (W - 2);
  endfunction

  function automatic logic [9*DW-1:0] model_window();
    logic [9*DW-1:0] win;
    win = '0;
    if (model_valid()) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[(3*i + j)*DW +: DW] = m_pix[(model_row() + i) * W + model_col() + j];
    end
    return win;
  endfunction

  function automatic logic [9*DW-1:0] pack9(input int v[9]);
    logic [9*DW-1:0] win;
    for (int k = 0; k < 9; k++) win[k*DW +: DW] = DW'(v[k]);
    return win;
  endfunction

  function automatic bit has_ff(input logic [9*DW-1:0] win);
    for (int k = 0; k < 9; k++)
      if (win[k*DW +: DW] === 8'hFF) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs, let the clock edge pass, then advance the
  // model by what that cycle should have done. Called at posedge+1.
  task automatic applyStimulus(input logic w, input logic [DW-1:0] d,
                               input logic c, input logic rdy);
    bit v;
    bus.wr        = w;
    bus.din       = d;
    bus.clear     = c;
    bus.win_ready = rdy;
    v = model_valid();
    @(posedge clk);
    #1;
    if (c) begin
      m_stored   = 0;
      m_accepted = 0;
    end else begin
      if (w && m_stored < NPIX) begin
        m_pix[m_stored] = d;
        m_stored++;
      end
      if (v && rdy) m_accepted++;
    end
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.wr        = 1'b1;
    bus.din       = 8'hFF;
    bus.clear     = 1'b0;
    bus.win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %b want 0", bus.full); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
    vectors++; if (bus.win_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", bus.win_valid); end
    vectors++; if (bus.win_data !== '0) begin miscompares++; $display("[TB] FAIL reset_data: got %h want 0", bus.win_data); end
    vectors++; if (bus.win_row !== '0) begin miscompares++; $display("[TB] FAIL reset_row: got %0d want 0", bus.win_row); end
    vectors++; if (bus.win_col !== '0) begin miscompares++; $display("[TB] FAIL reset_col: got %0d want 0", bus.win_col); end
    bus.wr        = 1'b0;
    bus.din       = '0;
    bus.win_ready = 1'b0;
    rst           = 1'b1;
    m_stored      = 0;
    m_accepted    = 0;
  endtask

  task automatic test_fill();
    int exp_v[9];
    exp_v = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    for (int i = 0; i < NPIX; i++) begin
      vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_full_early: got %b want 0 at pixel %0d", bus.full, i); end
      applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
    end
    vectors++; if (bus.full !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_full: got %b want 1", bus.full); end
    vectors++; if (bus.win_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_valid: got %b want 1", bus.win_valid); end
    vectors++; if (bus.win_data !== pack9(exp_v)) begin miscompares++; $display("[TB] FAIL fill_first_window: got %h want %h", bus.win_data, pack9(exp_v)); end
    vectors++; if (bus.win_data !== model_window()) begin miscompares++; $display("[TB] FAIL fill_model_window: got %h want %h", bus.win_data, model_window()); end
    vectors++; if (bus.win_row !== 2'd0 || bus.win_col !== 2'd0) begin miscompares++; $display("[TB] FAIL fill_pos: got (%0d,%0d) want (0,0)", bus.win_row, bus.win_col); end
  endtask

  task automatic test_extra_write();
    for (int n = 0; n < 2; n++) begin
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
      vectors++; if (bus.win_data !== model_window() || has_ff(bus.win_data)) begin miscompares++; $display("[TB] FAIL extra_write_window: got %h want %h", bus.win_data, model_window()); end
      vectors++; if (bus.win_valid !== 1'b1 || bus.full !== 1'b1) begin miscompares++; $display("[TB] FAIL extra_write_flags: got valid=%b full=%b want 1 1", bus.win_valid, bus.full); end
    end
  endtask

  task automatic test_backpressure();
    int exp_v[9];
    exp_v = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      vectors++; if (bus.win_data !== pack9(exp_v)) begin miscompares++; $display("[TB] FAIL bp_data: got %h want %h", bus.win_data, pack9(exp_v)); end
      vectors++; if (bus.win_col !== 2'd1 || bus.win_row !== 2'd0 || bus.win_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_pos: got (%0d,%0d) valid=%b want (0,1) valid=1", bus.win_row, bus.win_col, bus.win_valid); end
    end
  endtask

  task automatic test_sweep();
    int exp_last[9];
    int exp_r[3];
    int exp_c[3];
    exp_last = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    exp_r    = '{0, 1, 1};
    exp_c    = '{1, 0, 1};
    for (int k = 0; k < 3; k++) begin
      vectors++; if (bus.win_row !== 2'(exp_r[k]) || bus.win_col !== 2'(exp_c[k])) begin miscompares++; $display("[TB] FAIL sweep_pos: got (%0d,%0d) want (%0d,%0d)", bus.win_row, bus.win_col, exp_r[k], exp_c[k]); end
      vectors++; if (bus.win_data !== model_window() || has_ff(bus.win_data)) begin miscompares++; $display("[TB] FAIL sweep_data: got %h want %h", bus.win_data, model_window()); end
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL sweep_done_early: got %b want 0", bus.done); end
      if (k == 2) begin
        vectors++; if (bus.win_data !== pack9(exp_last)) begin miscompares++; $display("[TB] FAIL sweep_last_window: got %h want %h", bus.win_data, pack9(exp_last)); end
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
    end
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("[TB] FAIL sweep_done: got %b want 1", bus.done); end
    vectors++; if (bus.win_valid !== 1'b0 || bus.win_data !== '0) begin miscompares++; $display("[TB] FAIL sweep_after_done: got valid=%b data=%h want 0 0", bus.win_valid, bus.win_data); end
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b1);
    vectors++; if (bus.done !== 1'b1 || bus.full !== 1'b1 || bus.win_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL done_hold: got done=%b full=%b valid=%b want 1 1 0", bus.done, bus.full, bus.win_valid); end
  endtask

  task automatic test_clear_mid_send();
    int exp_v[9];
    exp_v = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    vectors++; if (bus.full !== 1'b0 || bus.done !== 1'b0 || bus.win_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL clear_from_done: got full=%b done=%b valid=%b want 0 0 0", bus.full, bus.done, bus.win_valid); end
    for (int i = 0; i < NPIX; i++) applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    vectors++; if (bus.win_col !== 2'(model_col()) || bus.win_data !== model_window()) begin miscompares++; $display("[TB] FAIL clear_pre_col: got col=%0d data=%h want col=%0d data=%h", bus.win_col, bus.win_data, model_col(), model_window()); end
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    vectors++; if (bus.full !== 1'b0 || bus.done !== 1'b0 || bus.win_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL clear_flags: got full=%b done=%b valid=%b want 0 0 0", bus.full, bus.done, bus.win_valid); end
    vectors++; if (bus.win_row !== '0 || bus.win_col !== '0 || bus.win_data !== '0) begin miscompares++; $display("[TB] FAIL clear_counters: got (%0d,%0d) data=%h want (0,0) 0", bus.win_row, bus.win_col, bus.win_data); end
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("[TB] FAIL refill_full_early: got %b want 0 at pixel %0d", bus.full, i); end
      applyStimulus(1'b1, DW'(100 + i), 1'b0, 1'b0);
    end
    vectors++; if (bus.full !== 1'b1 || bus.win_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL refill_flags: got full=%b valid=%b want 1 1", bus.full, bus.win_valid); end
    vectors++; if (bus.win_data !== pack9(exp_v)) begin miscompares++; $display("[TB] FAIL refill_window: got %h want %h", bus.win_data, pack9(exp_v)); end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < NPIX; i++) applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    vectors++; if (bus.full !== 1'b0 || bus.done !== 1'b0 || bus.win_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_send_flags: got full=%b done=%b valid=%b want 0 0 0", bus.full, bus.done, bus.win_valid); end
    vectors++; if (bus.win_row !== '0 || bus.win_col !== '0 || bus.win_data !== '0) begin miscompares++; $display("[TB] FAIL arst_send_counters: got (%0d,%0d) data=%h want (0,0) 0", bus.win_row, bus.win_col, bus.win_data); end
    m_stored   = 0;
    m_accepted = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    vectors++; if (bus.full !== 1'b0 || bus.win_valid !== 1'b0 || bus.win_data !== '0) begin miscompares++; $display("[TB] FAIL arst_fill_outputs: got full=%b valid=%b data=%h want 0 0 0", bus.full, bus.win_valid, bus.win_data); end
    m_stored   = 0;
    m_accepted = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_refill_early: got %b want 0 at pixel %0d", bus.full, i); end
      applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b0);
    end
    vectors++; if (bus.full !== 1'b1 || bus.win_data !== model_window()) begin miscompares++; $display("[TB] FAIL arst_refill_window: got full=%b data=%h want 1 %h", bus.full, bus.win_data, model_window()); end
  endtask

  task automatic test_random_frames();
    int guard;
    for (int f = 0; f < 4; f++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      guard = 0;
      while (m_stored < NPIX && guard < 200) begin
        vectors++; if (bus.full !== model_full() || bus.win_valid !== model_valid()) begin miscompares++; $display("[TB] FAIL rand_fill_flags: got full=%b valid=%b want %b %b", bus.full, bus.win_valid, model_full(), model_valid()); end
        applyStimulus($urandom_range(0, 3) != 0, DW'($urandom), 1'b0, 1'($urandom));
        guard++;
      end
      guard = 0;
      while (m_accepted < NWIN && guard < 200) begin
        vectors++; if (bus.win_valid !== model_valid() || bus.full !== model_full() || bus.done !== model_done()) begin miscompares++; $display("[TB] FAIL rand_send_flags: got valid=%b full=%b done=%b want %b %b %b", bus.win_valid, bus.full, bus.done, model_valid(), model_full(), model_done()); end
        vectors++; if (bus.win_row !== 2'(model_row()) || bus.win_col !== 2'(model_col())) begin miscompares++; $display("[TB] FAIL rand_send_pos: got (%0d,%0d) want (%0d,%0d)", bus.win_row, bus.win_col, model_row(), model_col()); end
        vectors++; if (bus.win_data !== model_window()) begin miscompares++; $display("[TB] FAIL rand_send_data: got %h want %h", bus.win_data, model_window()); end
        applyStimulus(1'($urandom), DW'($urandom), 1'b0, (f == 0) ? 1'b1 : ($urandom_range(0, 2) != 0));
        guard++;
      end
      vectors++; if (bus.done !== 1'b1 || bus.win_valid !== 1'b0 || bus.win_data !== '0) begin miscompares++; $display("[TB] FAIL rand_frame_end: got done=%b valid=%b data=%h want 1 0 0 (frame %0d)", bus.done, bus.win_valid, bus.win_data, f); end
    end
  endtask

  // Safety net so the run always ends even if something stalls.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    bus.wr        = 1'b0;
    bus.din       = '0;
    bus.clear     = 1'b0;
    bus.win_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) m_pix[i] = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_extra_write();
    test_backpressure();
    test_sweep();
    test_clear_mid_send();
    test_async_reset();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
